// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter.
// Optional burst cap is compiled in with HFRV_ARB_BURST_LIMIT_EN.
package hfrv_arb_pkg;

    // Bus ownership: CPU_OWN is both the reset state and the park state.
    typedef enum logic [1:0] {
        CPU_OWN,
        DMA_OWN,
        DRAIN
    } arb_state_t;

    // Width of the DMA beat counter (caps runs at up to 255 beats).
    localparam int ARB_BEAT_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the CPU port, DMA port and bus-mux port around the arbiter.
// Optional burst cap (HFRV_ARB_BURST_LIMIT_EN) does not change this bundle.
//
// Handshake semantics: a beat completes on a rising clock edge when the
// requester holds its request (cpu_access / dma_req), owns the bus
// (CPU while parked, DMA while dma_gnt = 1) and mem_stall = 0. The requester
// keeps address, write data and byte enables stable until that edge. Read
// data is valid the cycle after the beat; for DMA it is qualified by
// dma_rvalid, for the CPU by the absence of cpu_stall on the beat.
interface mem_bus_arbiter_if;

    logic [31:0] cpu_address;
    logic [31:0] cpu_data_out;
    logic [3:0]  cpu_data_w;
    logic        cpu_access;
    logic [31:0] cpu_data_in;
    logic        cpu_stall;

    logic        dma_req;
    logic [31:0] dma_address;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_we;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;

    logic [31:0] mem_address;
    logic [31:0] mem_data_write;
    logic [3:0]  mem_data_we;
    logic [31:0] mem_data_read;
    logic        mem_stall;

    // Arbiter side.
    modport slave (
        input  cpu_address, cpu_data_out, cpu_data_w, cpu_access,
        output cpu_data_in, cpu_stall,
        input  dma_req, dma_address, dma_wdata, dma_we,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_address, mem_data_write, mem_data_we,
        input  mem_data_read, mem_stall
    );

    // Environment side: CPU, DMA engine and bus mux.
    modport master (
        output cpu_address, cpu_data_out, cpu_data_w, cpu_access,
        input  cpu_data_in, cpu_stall,
        output dma_req, dma_address, dma_wdata, dma_we,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_address, mem_data_write, mem_data_we,
        output mem_data_read, mem_stall
    );

endinterface

// File: rtl/mem_bus_arbiter_burst_ctr.sv
// DMA beat counter with run-length limit compare.
// Present only when HFRV_ARB_BURST_LIMIT_EN is defined.
`ifdef HFRV_ARB_BURST_LIMIT_EN
module arb_burst_ctr
    import hfrv_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic beat,
    input  logic clear,
    output logic limit
);

    localparam logic [ARB_BEAT_W-1:0] LIMIT_C = ARB_BEAT_W'(MAX_BURST);

    logic [ARB_BEAT_W-1:0] count_q, count_d, count_inc;

    // Count completed beats; the run boundary (DRAIN) clears the count.
    always_comb begin
        count_inc = count_q + ARB_BEAT_W'(1);
        count_d   = count_q;
        if (clear) begin
            count_d = '0;
        end else if (beat) begin
            count_d = count_inc;
        end
    end

    // The beat that brings the count to the cap ends the run.
    assign limit = beat && (count_inc == LIMIT_C);

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (CPU + DMA) in front of the memory/peripheral bus mux.
// The bus parks on the CPU; DMA runs end with one DRAIN cycle so the last
// DMA read data is not handed to the CPU. Define HFRV_ARB_BURST_LIMIT_EN to
// cap each DMA run at MAX_BURST beats.
module mem_bus_arbiter
    import hfrv_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic             clock,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus,
    output arb_state_t       dbg_state
);

    arb_state_t state_q, state_d;
    logic       cpu_served_q, cpu_served_d;
    logic       rvalid_q, rvalid_d;
    logic       cpu_beat, dma_beat, take_bus, burst_limit;

    assign cpu_beat = (state_q == CPU_OWN) && bus.cpu_access && !bus.mem_stall;
    assign dma_beat = (state_q == DMA_OWN) && bus.dma_req && !bus.mem_stall;

    // The CPU access in the deciding cycle still completes, so a CPU beat
    // happening right now already counts as the CPU having been served.
    assign take_bus = bus.dma_req && !bus.mem_stall &&
                      (!bus.cpu_access || cpu_served_q || cpu_beat);

`ifdef HFRV_ARB_BURST_LIMIT_EN
    arb_burst_ctr #(
        .MAX_BURST(MAX_BURST)
    ) u_burst_ctr (
        .clock(clock),
        .reset(reset),
        .beat (dma_beat),
        .clear(state_q == DRAIN),
        .limit(burst_limit)
    );
`else
    assign burst_limit = 1'b0;
`endif

    // Ownership sequencing: CPU -> DMA costs nothing, DMA -> CPU goes via DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_OWN: if (take_bus) state_d = DMA_OWN;
            DMA_OWN: if (!bus.mem_stall && (!bus.dma_req || burst_limit)) state_d = DRAIN;
            DRAIN:   state_d = CPU_OWN;
            default: state_d = CPU_OWN;
        endcase
    end

    // cpu_served is held clear while away so it is clear on every CPU_OWN entry.
    always_comb begin
        cpu_served_d = cpu_served_q;
        if (state_q != CPU_OWN) begin
            cpu_served_d = 1'b0;
        end else if (cpu_beat) begin
            cpu_served_d = 1'b1;
        end
        rvalid_d = dma_beat && (bus.dma_we == 4'b0000);
    end

    // Bus steering and stall/grant generation; the CPU path is a plain mux.
    always_comb begin
        bus.mem_address    = bus.cpu_address;
        bus.mem_data_write = bus.cpu_data_out;
        bus.mem_data_we    = bus.cpu_data_w;
        bus.cpu_stall      = bus.mem_stall;
        bus.dma_gnt        = 1'b0;
        case (state_q)
            DMA_OWN: begin
                bus.mem_address    = bus.dma_address;
                bus.mem_data_write = bus.dma_wdata;
                // No write strobes leak out on a granted cycle without a request.
                bus.mem_data_we    = bus.dma_req ? bus.dma_we : 4'b0000;
                bus.cpu_stall      = bus.cpu_access;
                bus.dma_gnt        = 1'b1;
            end
            DRAIN: begin
                bus.mem_address    = bus.dma_address;
                bus.mem_data_write = bus.dma_wdata;
                bus.mem_data_we    = 4'b0000;
                bus.cpu_stall      = bus.cpu_access;
            end
            default: ;
        endcase
        // Nothing may write or claim the bus while reset is held.
        if (!reset) begin
            bus.mem_data_we = 4'b0000;
            bus.dma_gnt     = 1'b0;
        end
    end

    assign bus.cpu_data_in = bus.mem_data_read;
    assign bus.dma_rdata   = bus.mem_data_read;
    assign bus.dma_rvalid  = rvalid_q;
    assign dbg_state       = state_q;

    // State registers; reset aborts any DMA run and drops a pending rvalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= CPU_OWN;
            cpu_served_q <= 1'b0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_served_q <= cpu_served_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // MAX_BURST must fit the 8-bit beat counter.
    max_burst_range_a: assert property (@(posedge clock) (MAX_BURST >= 1) && (MAX_BURST <= 255));

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the single memory/peripheral bus in front of `perfipherals_busmux`. It shares the bus between the `datapath` CPU port and a DMA master port, and the bus is parked on the CPU. The block generates the CPU stall and the DMA grant, and sequences ownership handover with a drain cycle so that read data always reaches the correct master. Fairness is round-robin at transaction-run granularity, with an optional DMA burst cap.

## Interface
Parameters:
- `MAX_BURST`, default 8: maximum consecutive DMA beats per ownership run. Used only when the burst cap is compiled in. Range 1..255.

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `cpu_address`  in  32  CPU access address
- `cpu_data_out`  in  32  CPU write data
- `cpu_data_w`  in  4  CPU byte write enables; 0 means read
- `cpu_access`  in  1  CPU access request
- `cpu_data_in`  out  32  read data to CPU; passthrough of `mem_data_read`
- `cpu_stall`  out  1  stall to CPU
- `dma_req`  in  1  DMA beat request
- `dma_address`  in  32  DMA address
- `dma_wdata`  in  32  DMA write data
- `dma_we`  in  4  DMA byte enables; 0 means read
- `dma_gnt`  out  1  DMA owns the bus this cycle
- `dma_rdata`  out  32  passthrough of `mem_data_read`
- `dma_rvalid`  out  1  `dma_rdata` is valid for the previous DMA read beat
- `mem_address`  out  32  to bus mux `addr_mem`
- `mem_data_write`  out  32  to bus mux `data_write_mem`
- `mem_data_we`  out  4  to bus mux `data_we_mem`
- `mem_data_read`  in  32  from bus mux `data_read_mem`
- `mem_stall`  in  1  from bus mux `stall`

## Operation
- The FSM has three states:
  - CPU_OWN: reset state and park state.
  - DMA_OWN.
  - DRAIN.
- CPU_OWN:
  - Memory outputs are driven from the CPU inputs.
  - `cpu_stall = mem_stall`.
  - `dma_gnt = 0`.
- CPU beat: `cpu_access & ~mem_stall` in CPU_OWN. A CPU beat sets the `cpu_served` flag, which is cleared on entry to CPU_OWN.
- CPU_OWN to DMA_OWN happens when all of the following hold:
  - `dma_req = 1`
  - `mem_stall = 0`
  - `cpu_access = 0` or `cpu_served = 1`
  - The switch is decided at the rising edge. The CPU access in the deciding cycle still completes if it is unstalled.
- DMA_OWN:
  - Memory outputs are driven from the DMA inputs.
  - `dma_gnt = 1`.
  - `cpu_stall = cpu_access`.
- DMA beat: `dma_req & dma_gnt & ~mem_stall`. A DMA read beat (`dma_we = 0`) sets `dma_rvalid` in the next cycle.
- DMA_OWN to DRAIN happens when either condition holds:
  - `dma_req = 0`.
  - The burst cap is reached (see Configuration).
- DRAIN lasts one cycle:
  - `mem_data_we = 0`, `dma_gnt = 0`.
  - `cpu_stall = cpu_access`.
  - `dma_rvalid` may assert for the last DMA read.
  - DRAIN then goes unconditionally to CPU_OWN.
- While DMA_OWN is held, `mem_stall = 1` freezes the state and the beat counter.
- While `reset = 0`:
  - The state is CPU_OWN, `dma_rvalid = 0`, the beat counter is 0, and `cpu_served = 0`.
  - `mem_data_we` is forced to 0.
  - `dma_gnt = 0`.
- Reset asserted mid-DMA aborts the run immediately. No `dma_rvalid` is produced for the in-flight read.

## Timing
- CPU has zero added latency while parked. Arbitration is never on the CPU path in CPU_OWN.
- Read data arrives one cycle after the unstalled beat and is passed through combinationally.
- DMA acquisition latency from `dma_req` rising with an idle CPU: `dma_gnt` is 1 in the following cycle.
- `dma_rvalid` is registered, one cycle after each DMA read beat.
- Handover overhead: DMA to CPU costs 1 DRAIN cycle; CPU to DMA costs 0 extra cycles.
- When `cpu_access` and `dma_req` are asserted together in CPU_OWN with `cpu_served = 0`, the CPU wins one beat and DMA follows.

## Configuration
- Macro: `HFRV_ARB_BURST_LIMIT_EN`.
- When defined:
  - An 8-bit beat counter counts DMA beats in DMA_OWN.
  - When the beat that makes the count reach `MAX_BURST` completes, the FSM goes to DRAIN even if `dma_req` stays 1.
  - The counter clears in DRAIN.
  - Return to DMA_OWN then requires the CPU_OWN entry rule, so a pending CPU gets one beat first.
- When undefined:
  - There is no counter.
  - DMA holds the bus until `dma_req = 0`.
  - `MAX_BURST` is ignored.

## Structure
- Package `hfrv_arb_pkg` holds the following:
  - `typedef enum logic [1:0] {CPU_OWN, DMA_OWN, DRAIN} arb_state_t`.
  - `localparam` `ARB_BEAT_W = 8`.
- Sub-module `arb_burst_ctr` holds the counter and the limit compare. It is instantiated only under `HFRV_ARB_BURST_LIMIT_EN`.

## Test plan
- Reset is released with only CPU traffic: CPU reads `0x40000000` and gets `mem_data_read` the next cycle. `cpu_stall` mirrors `mem_stall`, and `dma_gnt` stays 0.
- Idle CPU and a 4-beat DMA write to `0x40000100..0x4000010C` with `dma_we = 0xF`:
  - `dma_gnt` is 1 for the 4 beats.
  - `mem_data_we = 0xF` on each beat.
  - DRAIN follows with `mem_data_we = 0`.
- DMA read burst of 3 beats: `dma_rvalid` pulses 3 times, each exactly one cycle after its beat, with the last pulse in DRAIN.
- `cpu_access` and `dma_req` rise in the same cycle in CPU_OWN:
  - The CPU completes 1 beat, then DMA is granted.
  - `cpu_stall = 1` through the DMA run plus DRAIN.
  - The CPU resumes immediately after DRAIN.
- With `HFRV_ARB_BURST_LIMIT_EN`, `MAX_BURST = 2`, `dma_req` held high, and `cpu_access` high, the pattern is: 2 DMA beats, DRAIN, 1 CPU beat, then DMA again, repeating.
- `reset` driven to 0 in the middle of DMA_OWN: `dma_gnt` drops asynchronously, `mem_data_we = 0`, `dma_rvalid = 0`, and the state is CPU_OWN after release.
